spi_cmd_framer: RTL and testbench
=================================

Name: spi_cmd_framer

Overview:
- Upstream feeder for the byte-oriented SPI master: converts register write/read commands into byte frames and buffers them in a show-ahead byte FIFO.
- The SPI master pulls bytes from this FIFO through its master_data, master_empty and master_rdreq handshake.
- A frame becomes visible only once all of its bytes are stored. This stops the master from ending a frame early on a transient empty.

Parameters:
- ADDR_BYTES, 1, header bytes per frame; header MSB is the R/W bit.
- DATA_BYTES, 1, data bytes per frame, sent MSB-first.
- DEPTH_LOG2, 4, log2 of FIFO depth in bytes; 2**DEPTH_LOG2 must be at least ADDR_BYTES+DATA_BYTES.
- READ_BIT_VAL, 1, header MSB value that marks a read.

Ports:
- sclk  in  1  system clock, posedge only.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  framer can accept a command this cycle.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  8*ADDR_BYTES-1  register address.
- cmd_data  in  8*DATA_BYTES  write data; ignored for reads.
- out_data  out  8  byte at FIFO head; valid while !out_empty.
- out_empty  out  1  no committed byte available.
- out_rdreq  in  1  pop head byte at this edge.
- used  out  DEPTH_LOG2+1  committed bytes not yet popped.
- overflow_err  out  1  sticky; set when cmd_valid is asserted while !cmd_ready for 256 consecutive cycles.

Behaviour:
- Clock and reset: one clock (sclk); reset is asynchronous and active-high (rst).
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after; out_empty=1; used=0; overflow_err=0; out_data=mem[0] (don't-care); all pointers and state at 0/IDLE.
- FRAME_LEN = ADDR_BYTES+DATA_BYTES.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1).
- Header: {rw_bit, cmd_addr}, where rw_bit = READ_BIT_VAL when cmd_rw=1, else its inverse.
- Payload: read frames carry DATA_BYTES bytes of 0x00 (dummy clocks); write frames carry cmd_data, most-significant byte first.
- FSM IDLE:
  - cmd_ready = (2**DEPTH_LOG2 - (wr_ptr-rd_ptr)) >= FRAME_LEN.
  - On cmd_valid & cmd_ready, latch header and payload into a FRAME_LEN*8-bit shift register, clear byte_cnt, go to LOAD.
- FSM LOAD:
  - cmd_ready=0.
  - Each cycle: mem[wr_ptr] <= shreg MSB byte; wr_ptr+1; shreg shifts left 8; byte_cnt+1.
  - On the FRAME_LEN-th write: commit_ptr <= wr_ptr+1 and return to IDLE.
- Latency: command accepted at edge k; bytes written at edges k+1..k+FRAME_LEN; out_empty falls after edge k+FRAME_LEN. Minimum command spacing is FRAME_LEN+1 cycles.
- out_empty = (commit_ptr == rd_ptr). out_data = mem[rd_ptr[DEPTH_LOG2-1:0]], combinational read (show-ahead).
- out_rdreq:
  - When !out_empty: rd_ptr+1.
  - When out_empty: ignored, no pointer change.
- Simultaneous pop and write/commit are both honoured. Free space counts uncommitted bytes as occupied.
- used = commit_ptr - rd_ptr.
- Full FIFO: cmd_ready stays 0. No byte is ever dropped or overwritten.
- overflow_err: a saturating 8-bit stall counter increments while cmd_valid & !cmd_ready and clears on acceptance or on !cmd_valid. The flag sets when the counter reaches 255 and clears only on rst.
- Reset mid-LOAD: the partial frame is discarded. Nothing past commit_ptr is ever visible.
- cmd_valid must stay high with stable fields until cmd_ready. The framer samples the fields only at the accepting edge.

Decomposition:
- Shared package spi_pkg holds:
  - FRAME_LEN computation function;
  - FSM state typedef (IDLE, LOAD);
  - byte width constant 8.
- One natural sub-module, spi_byte_fifo_commit: dual-pointer show-ahead memory with write, commit and pop ports plus the used count. The framer FSM and header build stay in the top.

Test Plan:
- Write command: defaults, cmd_rw=0, addr=0x15, data=0xA7.
  - Bus: out_empty falls 2 cycles after accept.
  - Pops: 0x15 then 0xA7.
  - Status: used goes 2→1→0.
- Read command: addr=0x7F, READ_BIT_VAL=1.
  - Bytes: 0xFF then 0x00.
  - Readiness: cmd_ready low for 2 cycles after accept, then high.
- Back-to-back writes with no pops: 8 commands accepted.
  - Full: at used=16, cmd_ready stays 0.
  - Release: one pop leaves cmd_ready at 0 (free=1<2); a second pop sets cmd_ready=1.
- Commit atomicity, ADDR_BYTES=2 and DATA_BYTES=2, with pops attempted every cycle:
  - out_empty stays 1 until all 4 bytes are written, then all 4 bytes pop in order.
  - Pops issued while empty leave rd_ptr unchanged.
- Reset and stall:
  - Assert rst one cycle into LOAD: after release, out_empty=1, used=0, cmd_ready=1, and no stale bytes appear.
  - Hold cmd_valid against a full FIFO for 256 cycles: overflow_err=1, and it stays set after draining.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command framer and its byte FIFO.
package spi_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    function automatic int unsigned frame_len(input int unsigned addr_bytes,
                                              input int unsigned data_bytes);
        return addr_bytes + data_bytes;
    endfunction

endpackage

// File: rtl/spi_byte_fifo_commit.sv
// Show-ahead byte FIFO with a separate commit pointer: only bytes below
// commit_ptr are visible to the reader, while free space counts every written byte.
module spi_byte_fifo_commit
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [BYTE_W-1:0]   wr_byte,
    input  logic                commit,
    input  logic                rd_req,
    output logic [BYTE_W-1:0]   rd_byte,
    output logic                empty,
    output logic [DEPTH_LOG2:0] used,
    output logic [DEPTH_LOG2:0] free_next_c
);

    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [BYTE_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          pop;

    // Commit publishes everything up to and including the byte written this edge.
    always_comb begin
        pop          = rd_req && (commit_ptr_q != rd_ptr_q);
        wr_ptr_d     = wr_ptr_q + PW'(wr_en);
        commit_ptr_d = commit ? wr_ptr_d : commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        free_next_c  = PW'(DEPTH) - (wr_ptr_d - rd_ptr_d);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge sclk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_byte;
        end
    end

    assign rd_byte = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign empty   = (commit_ptr_q == rd_ptr_q);
    assign used    = commit_ptr_q - rd_ptr_q;

endmodule

// File: rtl/spi_cmd_framer.sv
// Turns register read/write commands into {R/W+addr, data} byte frames and
// loads them into a commit-gated FIFO drained by the SPI master.
module spi_cmd_framer
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_BYTES   = 1,
    parameter int unsigned DATA_BYTES   = 1,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter bit          READ_BIT_VAL = 1'b1
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic [8*ADDR_BYTES-2:0] cmd_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_data,
    output logic [BYTE_W-1:0]       out_data,
    output logic                    out_empty,
    input  logic                    out_rdreq,
    output logic [DEPTH_LOG2:0]     used,
    output logic                    overflow_err
);

    localparam int unsigned FRAME_LEN = frame_len(ADDR_BYTES, DATA_BYTES);
    localparam int unsigned SHW       = FRAME_LEN * BYTE_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned PW        = DEPTH_LOG2 + 1;
    localparam logic [7:0]  STALL_MAX = 8'hFF;

    state_t             state_q, state_d;
    logic [SHW-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [7:0]         stall_cnt_q, stall_cnt_d;
    logic               overflow_q, overflow_d;

    logic [BYTE_W*ADDR_BYTES-1:0] header_c;
    logic [BYTE_W*DATA_BYTES-1:0] payload_c;
    logic                         rw_bit_c;
    logic                         stall_c;
    logic                         wr_en_c;
    logic                         commit_c;
    logic [PW-1:0]                free_next_c;

    always_comb begin
        rw_bit_c  = cmd_rw ? READ_BIT_VAL : ~READ_BIT_VAL;
        header_c  = {rw_bit_c, cmd_addr};
        payload_c = cmd_rw ? '0 : cmd_data;
    end

    // Frame FSM plus stall watchdog; cmd_ready is precomputed from next-cycle pointers.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        byte_cnt_d  = byte_cnt_q;
        wr_en_c     = 1'b0;
        commit_c    = 1'b0;
        stall_c     = cmd_valid && !cmd_ready_q;
        stall_cnt_d = '0;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    shreg_d    = {header_c, payload_c};
                    byte_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                wr_en_c    = 1'b1;
                shreg_d    = {shreg_q[SHW-BYTE_W-1:0], {BYTE_W{1'b0}}};
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                if (byte_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    commit_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stall_c) begin
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 8'd1;
            if (stall_cnt_q == STALL_MAX) begin
                overflow_d = 1'b1;
            end
        end

        cmd_ready_d = (state_d == IDLE) && (free_next_c >= PW'(FRAME_LEN));
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            byte_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            stall_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            stall_cnt_q <= stall_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    spi_byte_fifo_commit #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .sclk        (sclk),
        .rst         (rst),
        .wr_en       (wr_en_c),
        .wr_byte     (shreg_q[SHW-1 -: BYTE_W]),
        .commit      (commit_c),
        .rd_req      (out_rdreq),
        .rd_byte     (out_data),
        .empty       (out_empty),
        .used        (used),
        .free_next_c (free_next_c)
    );

    assign cmd_ready    = cmd_ready_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Self-checking bench for spi_cmd_framer: directed scenarios plus a randomized
// run against a byte-queue reference model.
module tb_spi_cmd_framer;

    logic sclk = 1'b0;
    logic rst;
    always #5 sclk = ~sclk;

    // Default-parameter instance (1 addr byte, 1 data byte, 16-byte FIFO)
    logic       cmd_valid, cmd_ready, cmd_rw, out_empty, out_rdreq, overflow_err;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data, out_data;
    logic [4:0] used;

    // Wide-frame instance (2 addr bytes, 2 data bytes)
    logic        b_cmd_valid, b_cmd_ready, b_cmd_rw, b_out_empty, b_out_rdreq, b_overflow_err;
    logic [14:0] b_cmd_addr;
    logic [15:0] b_cmd_data;
    logic [7:0]  b_out_data;
    logic [4:0]  b_used;

    spi_cmd_framer dut (
        .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .out_data(out_data), .out_empty(out_empty), .out_rdreq(out_rdreq),
        .used(used), .overflow_err(overflow_err)
    );

    spi_cmd_framer #(.ADDR_BYTES(2), .DATA_BYTES(2)) dut_b (
        .sclk(sclk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_rw(b_cmd_rw), .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
        .out_data(b_out_data), .out_empty(b_out_empty), .out_rdreq(b_out_rdreq),
        .used(b_used), .overflow_err(b_overflow_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model for the default instance: bytes written so far, bytes
    // visible to the reader, and the frame currently being loaded.
    logic [7:0] m_q[$];
    logic [7:0] m_pend[$];
    int         m_occ;
    int         m_load_rem;
    int         m_stall_run;
    bit         m_ovf;
    bit         m_accepted;

    function automatic bit exp_ready();
        return (m_load_rem == 0) && ((16 - m_occ) >= 2);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend.delete();
        m_occ       = 0;
        m_load_rem  = 0;
        m_stall_run = 0;
        m_ovf       = 1'b0;
        m_accepted  = 1'b0;
    endtask

    // Effect of one clock edge given the inputs currently driven.
    task automatic model_edge();
        bit rdy;
        rdy = exp_ready();
        if (cmd_valid && !rdy) begin
            m_stall_run++;
            if (m_stall_run >= 256) m_ovf = 1'b1;
        end else begin
            m_stall_run = 0;
        end
        if (out_rdreq && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_occ--;
        end
        if (m_load_rem > 0) begin
            m_occ++;
            m_load_rem--;
            if (m_load_rem == 0) begin
                foreach (m_pend[i]) m_q.push_back(m_pend[i]);
                m_pend.delete();
            end
        end
        m_accepted = cmd_valid && rdy;
        if (m_accepted) begin
            m_pend.push_back({cmd_rw, cmd_addr});
            m_pend.push_back(cmd_rw ? 8'h00 : cmd_data);
            m_load_rem = 2;
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge sclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_data = '0; out_rdreq = 0;
        b_cmd_valid = 0; b_cmd_rw = 0; b_cmd_addr = '0; b_cmd_data = '0; b_out_rdreq = 0;
        @(negedge sclk);
        @(negedge sclk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=0", cmd_ready); end
        checks++; if (out_empty !== 1'b1) begin failures++; $display("FAIL reset_out_empty got=%0b exp=1", out_empty); end
        checks++; if (used !== 5'd0) begin failures++; $display("FAIL reset_used got=%0d exp=0", used); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow_err); end
        model_reset();
        rst = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_cmd_ready got=%0b exp=1", cmd_ready); end
        checks++; if (b_cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_b_cmd_ready got=%0b exp=1", b_cmd_ready); end
    endtask

    task automatic test_write();
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h15; cmd_data = 8'hA7;
        tick();
        cmd_valid = 0;
        checks++; if (out_empty !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL write_k0 got empty=%0b ready=%0b exp empty=1 ready=0", out_empty, cmd_ready); end
        tick();
        checks++; if (out_empty !== 1'b1) begin failures++; $display("FAIL write_k1_empty got=%0b exp=1", out_empty); end
        tick();
        checks++; if (out_empty !== 1'b0 || used !== 5'd2) begin failures++; $display("FAIL write_k2 got empty=%0b used=%0d exp empty=0 used=2", out_empty, used); end
        checks++; if (out_data !== 8'h15) begin failures++; $display("FAIL write_hdr got=%0h exp=15", out_data); end
        out_rdreq = 1;
        tick();
        checks++; if (out_data !== 8'hA7 || used !== 5'd1) begin failures++; $display("FAIL write_data got=%0h used=%0d exp=a7 used=1", out_data, used); end
        tick();
        out_rdreq = 0;
        checks++; if (out_empty !== 1'b1 || used !== 5'd0) begin failures++; $display("FAIL write_drained got empty=%0b used=%0d exp empty=1 used=0", out_empty, used); end
    endtask

    task automatic test_read();
        cmd_valid = 1; cmd_rw = 1; cmd_addr = 7'h7F; cmd_data = 8'($urandom);
        tick();
        cmd_valid = 0;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL read_ready_k0 got=%0b exp=0", cmd_ready); end
        tick();
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL read_ready_k1 got=%0b exp=0", cmd_ready); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL read_ready_k2 got=%0b exp=1", cmd_ready); end
        checks++; if (out_data !== 8'hFF) begin failures++; $display("FAIL read_hdr got=%0h exp=ff", out_data); end
        out_rdreq = 1;
        tick();
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL read_dummy got=%0h exp=00", out_data); end
        tick();
        out_rdreq = 0;
        checks++; if (out_empty !== 1'b1) begin failures++; $display("FAIL read_drained got=%0b exp=1", out_empty); end
    endtask

    logic [7:0] fill_exp[$];

    task automatic test_back_to_back();
        fill_exp.delete();
        for (int n = 0; n < 8; n++) begin
            cmd_valid = 1; cmd_rw = 1'($urandom); cmd_addr = 7'($urandom); cmd_data = 8'($urandom);
            fill_exp.push_back({cmd_rw, cmd_addr});
            fill_exp.push_back(cmd_rw ? 8'h00 : cmd_data);
            checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%0b exp=1", n, cmd_ready); end
            tick();
            cmd_valid = 0;
            tick();
            tick();
        end
        checks++; if (used !== 5'd16 || cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got used=%0d ready=%0b exp used=16 ready=0", used, cmd_ready); end
        checks++; if (out_data !== fill_exp[0]) begin failures++; $display("FAIL b2b_head got=%0h exp=%0h", out_data, fill_exp[0]); end
    endtask

    task automatic test_overflow_and_release();
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'($urandom); cmd_data = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 199) begin
                checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", overflow_err); end
            end
        end
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow_err); end
        checks++; if (cmd_ready !== 1'b0 || used !== 5'd16) begin failures++; $display("FAIL full_hold got ready=%0b used=%0d exp ready=0 used=16", cmd_ready, used); end
        cmd_valid = 0;
        out_rdreq = 1;
        tick();
        out_rdreq = 0;
        checks++; if (cmd_ready !== 1'b0 || used !== 5'd15) begin failures++; $display("FAIL release_one got ready=%0b used=%0d exp ready=0 used=15", cmd_ready, used); end
        checks++; if (out_data !== fill_exp[1]) begin failures++; $display("FAIL release_data got=%0h exp=%0h", out_data, fill_exp[1]); end
        out_rdreq = 1;
        tick();
        out_rdreq = 0;
        checks++; if (cmd_ready !== 1'b1 || used !== 5'd14) begin failures++; $display("FAIL release_two got ready=%0b used=%0d exp ready=1 used=14", cmd_ready, used); end
        for (int i = 2; i < 16; i++) begin
            checks++; if (out_data !== fill_exp[i]) begin failures++; $display("FAIL drain_%0d got=%0h exp=%0h", i, out_data, fill_exp[i]); end
            out_rdreq = 1;
            tick();
        end
        out_rdreq = 0;
        checks++; if (out_empty !== 1'b1 || overflow_err !== 1'b1) begin failures++; $display("FAIL drained_sticky got empty=%0b ovf=%0b exp empty=1 ovf=1", out_empty, overflow_err); end
    endtask

    task automatic test_commit_atomic();
        logic [7:0] bytes[4];
        logic [15:0] hdr;
        b_out_rdreq = 1;
        for (int f = 0; f < 2; f++) begin
            b_cmd_valid = 1; b_cmd_rw = 1'(f); b_cmd_addr = 15'($urandom); b_cmd_data = 16'($urandom);
            hdr = {b_cmd_rw, b_cmd_addr};
            bytes[0] = hdr[15:8];
            bytes[1] = hdr[7:0];
            bytes[2] = b_cmd_rw ? 8'h00 : b_cmd_data[15:8];
            bytes[3] = b_cmd_rw ? 8'h00 : b_cmd_data[7:0];
            checks++; if (b_cmd_ready !== 1'b1) begin failures++; $display("FAIL atomic_ready_%0d got=%0b exp=1", f, b_cmd_ready); end
            tick();
            b_cmd_valid = 0;
            for (int j = 0; j < 4; j++) begin
                checks++; if (b_out_empty !== 1'b1 || b_used !== 5'd0) begin failures++; $display("FAIL atomic_hidden_%0d_%0d got empty=%0b used=%0d exp empty=1 used=0", f, j, b_out_empty, b_used); end
                tick();
            end
            for (int j = 0; j < 4; j++) begin
                checks++; if (b_out_data !== bytes[j] || b_used !== 5'(4 - j)) begin failures++; $display("FAIL atomic_pop_%0d_%0d got=%0h used=%0d exp=%0h used=%0d", f, j, b_out_data, b_used, bytes[j], 4 - j); end
                tick();
            end
            tick();
            checks++; if (b_out_empty !== 1'b1 || b_used !== 5'd0) begin failures++; $display("FAIL atomic_empty_%0d got empty=%0b used=%0d exp empty=1 used=0", f, b_out_empty, b_used); end
        end
        b_out_rdreq = 0;
    endtask

    task automatic test_reset_mid_load();
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h33; cmd_data = 8'h44;
        tick();
        cmd_valid = 0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (out_empty !== 1'b1 || used !== 5'd0 || cmd_ready !== 1'b0) begin failures++; $display("FAIL midload_in_reset got empty=%0b used=%0d ready=%0b exp 1/0/0", out_empty, used, cmd_ready); end
        @(negedge sclk);
        model_reset();
        rst = 1'b0;
        tick();
        checks++; if (out_empty !== 1'b1 || used !== 5'd0 || cmd_ready !== 1'b1 || overflow_err !== 1'b0) begin failures++; $display("FAIL midload_after got empty=%0b used=%0d ready=%0b ovf=%0b exp 1/0/1/0", out_empty, used, cmd_ready, overflow_err); end
        out_rdreq = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_empty !== 1'b1 || used !== 5'd0) begin failures++; $display("FAIL midload_stale_%0d got empty=%0b used=%0d exp empty=1 used=0", i, out_empty, used); end
        end
        out_rdreq = 0;
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h5A; cmd_data = 8'hC3;
        tick();
        cmd_valid = 0;
        tick();
        tick();
        checks++; if (out_data !== 8'h5A || used !== 5'd2) begin failures++; $display("FAIL midload_new_hdr got=%0h used=%0d exp=5a used=2", out_data, used); end
        out_rdreq = 1;
        tick();
        checks++; if (out_data !== 8'hC3) begin failures++; $display("FAIL midload_new_data got=%0h exp=c3", out_data); end
        tick();
        out_rdreq = 0;
        checks++; if (out_empty !== 1'b1) begin failures++; $display("FAIL midload_new_drained got=%0b exp=1", out_empty); end
    endtask

    task automatic test_random();
        int pop_pct;
        cmd_valid = 0;
        m_accepted = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            checks++; if (cmd_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, cmd_ready, exp_ready()); end
            checks++; if (out_empty !== (m_q.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%0b exp=%0b", i, out_empty, m_q.size() == 0); end
            checks++; if (used !== 5'(m_q.size())) begin failures++; $display("FAIL rnd_used cyc=%0d got=%0d exp=%0d", i, used, m_q.size()); end
            checks++; if (overflow_err !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", i, overflow_err, m_ovf); end
            if (m_q.size() > 0) begin
                checks++; if (out_data !== m_q[0]) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", i, out_data, m_q[0]); end
            end
            if (!(cmd_valid && !m_accepted)) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_rw    = 1'($urandom);
                cmd_addr  = 7'($urandom);
                cmd_data  = 8'($urandom);
            end
            pop_pct   = (i < 700) ? 25 : 75;
            out_rdreq = ($urandom_range(0, 99) < pop_pct);
            tick();
        end
        cmd_valid = 0;
        out_rdreq = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_overflow_and_release();
        test_commit_atomic();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
